// File: rtl/arith_lane_pipe_pkg.sv
// Shared opcodes and saturation-bound helpers for the multi-lane arithmetic pipe.
`timescale 1ns/1ps
package arith_lane_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Bounds are returned 64 bits wide; callers keep the low acc_w bits.
  function automatic logic [63:0] sat_max(input int unsigned acc_w, input logic is_signed);
    return is_signed ? ((64'd1 << (acc_w - 1)) - 64'd1) : ((64'd1 << acc_w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned acc_w, input logic is_signed);
    return is_signed ? (~64'd0 << (acc_w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/arith_lane_pipe_lane.sv
// One lane's S2 datapath: add / multiply / saturating MAC with a persistent accumulator.
`timescale 1ns/1ps
module arith_lane
  import arith_lane_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 20,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] res,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int XW = ACC_W + 1;
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED));

  logic [ACC_W-1:0] acc_q, acc_d, res_q, res_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    a_p, b_p, prod;
  logic [XW-1:0]    a_x, b_x, p_x, acc_x, sum_ab, sum_mac;
  logic [ACC_W-1:0] mac_sat;
  logic             mac_ovf;

  always_comb begin
    a_p     = {{WIDTH{SIGNED & a[WIDTH-1]}}, a};
    b_p     = {{WIDTH{SIGNED & b[WIDTH-1]}}, b};
    prod    = a_p * b_p;
    a_x     = {{(XW-WIDTH){SIGNED & a[WIDTH-1]}}, a};
    b_x     = {{(XW-WIDTH){SIGNED & b[WIDTH-1]}}, b};
    p_x     = {{(XW-PW){SIGNED & prod[PW-1]}}, prod};
    acc_x   = {SIGNED & acc_q[ACC_W-1], acc_q};
    sum_ab  = a_x + b_x;
    sum_mac = acc_x + p_x;
    // One guard bit: signed overflow shows as disagreement between the top two bits.
    if (SIGNED) begin
      mac_ovf = sum_mac[XW-1] ^ sum_mac[ACC_W-1];
      mac_sat = mac_ovf ? (sum_mac[XW-1] ? MIN_V : MAX_V) : sum_mac[ACC_W-1:0];
    end else begin
      mac_ovf = sum_mac[XW-1];
      mac_sat = mac_ovf ? MAX_V : sum_mac[ACC_W-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    ovf_d = ovf_q;
    if (adv) begin
      case (op)
        OP_ADD: begin res_d = sum_ab[ACC_W-1:0]; ovf_d = 1'b0; end
        OP_MUL: begin res_d = p_x[ACC_W-1:0];    ovf_d = 1'b0; end
        OP_MAC: begin res_d = mac_sat; ovf_d = mac_ovf; acc_d = mac_sat; end
        default: begin res_d = '0; ovf_d = 1'b0; acc_d = '0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res = res_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/arith_lane_pipe.sv
// Two-stage multi-lane arithmetic pipe: S1 captures operands, S2 (per lane) computes and holds results.
`timescale 1ns/1ps
module arith_lane_pipe
  import arith_lane_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = 20,
  parameter bit SIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_res,
  output logic [LANES-1:0]       out_ovf
);

  logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  op_e                    s1_op_q, s1_op_d;
  logic [LANES*WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                   stall, adv;

  // Handshake: a beat moves on valid && ready at the clock edge. The whole pipe
  // freezes only while S2 holds an unaccepted result, so an empty S2 never blocks S1.
  assign stall    = s2_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign adv      = s1_valid_q & ~stall;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_op_d = op_e'(in_op);
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  assign out_valid = s2_valid_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    arith_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .SIGNED(SIGNED)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .adv(adv),
      .op (s1_op_q),
      .a  (s1_a_q[i*WIDTH +: WIDTH]),
      .b  (s1_b_q[i*WIDTH +: WIDTH]),
      .res(out_res[i*ACC_W +: ACC_W]),
      .ovf(out_ovf[i])
    );
  end

endmodule

// File: tb/tb_arith_lane_pipe.sv
// Bench for arith_lane_pipe: directed scenarios plus random traffic against an integer reference model.
`timescale 1ns/1ps
module tb_arith_lane_pipe;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int ACC_W = 20;
  localparam bit SIGNED = 1'b1;
  localparam int EW = LANES * ACC_W + LANES;
  localparam logic [1:0] ADD = 2'b00, MUL = 2'b01, MAC = 2'b10, CLR = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [1:0]             in_op = 2'b00;
  logic [LANES*WIDTH-1:0] in_a = '0, in_b = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*ACC_W-1:0] out_res;
  logic [LANES-1:0]       out_ovf;

  arith_lane_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W), .SIGNED(SIGNED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int failed = 0;

  // Reference model state and scoreboard
  longint                 acc_m [LANES];
  logic [EW-1:0]          exp_q[$];
  logic [LANES*ACC_W-1:0] obs_res_q[$];
  logic [LANES-1:0]       obs_ovf_q[$];
  int                     obs_cyc_q[$];
  int                     last_acc_cyc = 0;
  int                     n_in = 0, n_out = 0;
  bit                     stall_seen = 0;

  function automatic longint ext(input logic [WIDTH-1:0] v);
    if (SIGNED) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [1:0] op,
                                               input logic [LANES*WIDTH-1:0] a,
                                               input logic [LANES*WIDTH-1:0] b);
    logic [EW-1:0] ret;
    longint av, bv, r, hi, lo;
    logic o;
    hi = SIGNED ? (64'sd1 <<< (ACC_W - 1)) - 1 : (64'sd1 <<< ACC_W) - 1;
    lo = SIGNED ? -(64'sd1 <<< (ACC_W - 1)) : 0;
    ret = '0;
    for (int l = 0; l < LANES; l++) begin
      av = ext(a[l*WIDTH +: WIDTH]);
      bv = ext(b[l*WIDTH +: WIDTH]);
      o = 1'b0;
      case (op)
        ADD: r = av + bv;
        MUL: r = av * bv;
        MAC: begin
          r = acc_m[l] + av * bv;
          if (r > hi) begin r = hi; o = 1'b1; end
          else if (r < lo) begin r = lo; o = 1'b1; end
          acc_m[l] = r;
        end
        default: begin r = 0; acc_m[l] = 0; end
      endcase
      ret[l*ACC_W +: ACC_W] = ACC_W'(r);
      ret[LANES*ACC_W + l] = o;
    end
    return ret;
  endfunction

  // Observe handshakes mid-cycle; what is seen here completes at the next rising edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_q.delete();
      for (int l = 0; l < LANES; l++) acc_m[l] = 0;
    end else begin
      if (out_valid && out_ready) begin
        obs_res_q.push_back(out_res);
        obs_ovf_q.push_back(out_ovf);
        obs_cyc_q.push_back(cyc);
        n_out++;
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL scoreboard_extra: got res=%h ovf=%b with nothing expected", out_res, out_ovf);
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_res} !== e) begin
            failed++;
            $display("FAIL scoreboard_beat: got ovf=%b res=%h, expected ovf=%b res=%h",
                     out_ovf, out_res, e[EW-1 -: LANES], e[LANES*ACC_W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_op, in_a, in_b));
        last_acc_cyc = cyc;
        n_in++;
      end
      if (in_valid && !in_ready) stall_seen = 1;
    end
  end

  task automatic clear_obs();
    obs_res_q.delete();
    obs_ovf_q.delete();
    obs_cyc_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send_beat(input logic [1:0] op, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    bit took = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = {a1, a0};
    in_b     = {b1, b0};
    for (int k = 0; k < 64 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!took) begin
      tests_run++;
      failed++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 64 cycles", in_ready);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) begin
      tests_run++;
      failed++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run += 4;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (out_res !== '0) begin failed++; $display("FAIL reset_out_res: got %h, required 0", out_res); end
    if (out_ovf !== '0) begin failed++; $display("FAIL reset_out_ovf: got %b, required 00", out_ovf); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int a_c;
    logic [LANES*ACC_W-1:0] r;
    clear_obs();
    send_beat(ADD, 8'd127, 8'd1, 8'h80, 8'hFF);
    a_c = last_acc_cyc;
    drain();
    tests_run++;
    if (obs_res_q.size() != 1) begin
      failed++; $display("FAIL add_count: got %0d results, required 1", obs_res_q.size());
    end else begin
      r = obs_res_q[0];
      tests_run += 4;
      if (r[0 +: ACC_W] !== ACC_W'(128)) begin failed++; $display("FAIL add_lane0: got %0d, required 128", $signed(r[0 +: ACC_W])); end
      if (r[ACC_W +: ACC_W] !== ACC_W'(-129)) begin failed++; $display("FAIL add_lane1: got %0d, required -129", $signed(r[ACC_W +: ACC_W])); end
      if (obs_ovf_q[0] !== 2'b00) begin failed++; $display("FAIL add_ovf: got %b, required 00", obs_ovf_q[0]); end
      if (obs_cyc_q[0] - a_c !== 2) begin failed++; $display("FAIL add_latency: got %0d, required 2", obs_cyc_q[0] - a_c); end
    end
  endtask

  task automatic test_mul();
    logic [LANES*ACC_W-1:0] r;
    clear_obs();
    send_beat(MUL, 8'h80, 8'h80, 8'd127, 8'h80);
    drain();
    tests_run++;
    if (obs_res_q.size() != 1) begin
      failed++; $display("FAIL mul_count: got %0d results, required 1", obs_res_q.size());
    end else begin
      r = obs_res_q[0];
      tests_run += 2;
      if (r[0 +: ACC_W] !== ACC_W'(16384)) begin failed++; $display("FAIL mul_lane0: got %0d, required 16384", $signed(r[0 +: ACC_W])); end
      if (r[ACC_W +: ACC_W] !== ACC_W'(-16256)) begin failed++; $display("FAIL mul_lane1: got %0d, required -16256", $signed(r[ACC_W +: ACC_W])); end
    end
  endtask

  task automatic test_mac_stream();
    logic [LANES*ACC_W-1:0] r;
    clear_obs();
    send_beat(CLR, 8'd5, 8'd5, 8'd5, 8'd5);
    for (int i = 0; i < 4; i++) send_beat(MAC, 8'd100, 8'd100, 8'd100, 8'd100);
    drain();
    tests_run++;
    if (obs_res_q.size() != 5) begin
      failed++; $display("FAIL mac_count: got %0d results, required 5", obs_res_q.size());
    end else begin
      for (int i = 1; i <= 4; i++) begin
        r = obs_res_q[i];
        for (int l = 0; l < LANES; l++) begin
          tests_run++;
          if (r[l*ACC_W +: ACC_W] !== ACC_W'(i * 10000)) begin
            failed++; $display("FAIL mac_value beat%0d lane%0d: got %0d, required %0d", i, l, r[l*ACC_W +: ACC_W], i * 10000);
          end
        end
        tests_run++;
        if (obs_cyc_q[i] - obs_cyc_q[i-1] !== 1) begin
          failed++; $display("FAIL mac_spacing beat%0d: got gap %0d, required 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [LANES*ACC_W-1:0] r;
    int idx [3] = '{32, 33, 34};
    int want [3] = '{516128, 524287, 524286};
    logic [LANES-1:0] want_o [3] = '{2'b00, 2'b11, 2'b00};
    clear_obs();
    send_beat(CLR, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 33; i++) send_beat(MAC, 8'd127, 8'd127, 8'd127, 8'd127);
    send_beat(MAC, 8'd1, 8'hFF, 8'd1, 8'hFF);
    drain();
    tests_run++;
    if (obs_res_q.size() != 35) begin
      failed++; $display("FAIL sat_count: got %0d results, required 35", obs_res_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        r = obs_res_q[idx[k]];
        tests_run += 3;
        if (r[0 +: ACC_W] !== ACC_W'(want[k])) begin failed++; $display("FAIL sat_lane0 beat%0d: got %0d, required %0d", idx[k], r[0 +: ACC_W], want[k]); end
        if (r[ACC_W +: ACC_W] !== ACC_W'(want[k])) begin failed++; $display("FAIL sat_lane1 beat%0d: got %0d, required %0d", idx[k], r[ACC_W +: ACC_W], want[k]); end
        if (obs_ovf_q[idx[k]] !== want_o[k]) begin failed++; $display("FAIL sat_ovf beat%0d: got %b, required %b", idx[k], obs_ovf_q[idx[k]], want_o[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [LANES*ACC_W-1:0] r;
    clear_obs();
    stall_seen = 0;
    fork
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send_beat(ADD, 8'd1, 8'd2, 8'd3, 8'd4);
        send_beat(ADD, 8'd5, 8'd6, 8'd7, 8'd8);
        send_beat(ADD, 8'd9, 8'd10, 8'd11, 8'd12);
      end
    join
    drain();
    tests_run += 2;
    if (stall_seen !== 1'b1) begin failed++; $display("FAIL bp_in_ready_drop: got %b, required 1", stall_seen); end
    if (obs_res_q.size() != 3) begin
      failed++; $display("FAIL bp_count: got %0d results, required 3", obs_res_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = obs_res_q[i];
        tests_run += 2;
        if (r[0 +: ACC_W] !== ACC_W'(8 * i + 3)) begin failed++; $display("FAIL bp_order lane0 beat%0d: got %0d, required %0d", i, r[0 +: ACC_W], 8 * i + 3); end
        if (r[ACC_W +: ACC_W] !== ACC_W'(8 * i + 7)) begin failed++; $display("FAIL bp_order lane1 beat%0d: got %0d, required %0d", i, r[ACC_W +: ACC_W], 8 * i + 7); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [LANES*ACC_W-1:0] r;
    clear_obs();
    send_beat(CLR, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) send_beat(MAC, 8'd100, 8'd100, 8'd100, 8'd100);
    drain();
    out_ready = 1'b0;
    send_beat(MAC, 8'd100, 8'd100, 8'd100, 8'd100);
    send_beat(MAC, 8'd100, 8'd100, 8'd100, 8'd100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run += 3;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin failed++; $display("FAIL midreset_in_ready: got %b, required 1", in_ready); end
    if (out_res !== '0) begin failed++; $display("FAIL midreset_out_res: got %h, required 0", out_res); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    clear_obs();
    send_beat(MAC, 8'd2, 8'd3, 8'd2, 8'd3);
    drain();
    tests_run++;
    if (obs_res_q.size() != 1) begin
      failed++; $display("FAIL midreset_count: got %0d results, required 1", obs_res_q.size());
    end else begin
      r = obs_res_q[0];
      tests_run++;
      if (r !== {ACC_W'(6), ACC_W'(6)}) begin failed++; $display("FAIL midreset_mac: got %h, required both lanes 6", r); end
    end
  endtask

  task automatic test_random();
    bit took = 0;
    n_in = 0;
    n_out = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_a     = (LANES*WIDTH)'($urandom);
        in_b     = (LANES*WIDTH)'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (n_out !== n_in) begin failed++; $display("FAIL random_count: got %0d results, required %0d", n_out, n_in); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mac_stream();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
